// File: rtl/ram_72bit_bist_ctrl.sv
// ram_72bit_bist_ctrl: fill / read-back / compare BIST sequencer that owns the 72-bit RAM port while busy.
// Optional build macro RAM_BIST_CONTINUOUS_EN: loop passes until reset, rotating the pattern on every pass.
module ram_72bit_bist_ctrl #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 72,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            pattern_sel,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           err_count,
   output logic [ADDR_WIDTH-1:0] err_addr
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WRITE = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam int REPS  = (DATA_WIDTH + ADDR_WIDTH - 1) / ADDR_WIDTH;
   localparam int REP_W = REPS * ADDR_WIDTH;
   localparam int CB_W  = ((DATA_WIDTH + 1) / 2) * 2;
   localparam logic [CB_W-1:0]       CB_FULL  = {(CB_W / 2){2'b10}};
   localparam logic [DATA_WIDTH-1:0] WALK_ONE = {{(DATA_WIDTH - 1){1'b0}}, 1'b1};

   // Even-address checkerboard is 8'hAA per byte; the odd-address word is its inverse (8'h55).
   function automatic logic [DATA_WIDTH-1:0] pattern_word(input logic [1:0] sel,
                                                          input logic [ADDR_WIDTH-1:0] a);
      logic [REP_W-1:0]      rep;
      logic [DATA_WIDTH-1:0] word;
      rep = {REPS{a}};
      case (sel)
         2'd0:    word = rep[DATA_WIDTH-1:0];
         2'd1:    word = a[0] ? ~CB_FULL[DATA_WIDTH-1:0] : CB_FULL[DATA_WIDTH-1:0];
         2'd2:    word = WALK_ONE << (32'(a) % DATA_WIDTH);
         default: word = ~rep[DATA_WIDTH-1:0];
      endcase
      return word;
   endfunction

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [1:0]            drain_cnt;
   logic [1:0]            pat_q;
   logic                  done_q;
   logic                  pass_q;
   logic [DATA_WIDTH-1:0] pat_cur;
   logic                  start_ok;
   logic                  addr_last;
   logic                  drain_last;
   logic                  mismatch;
   logic [15:0]           err_next;

   logic                  vld_pipe  [RD_LATENCY];
   logic [DATA_WIDTH-1:0] exp_pipe  [RD_LATENCY];
   logic [ADDR_WIDTH-1:0] adr_pipe  [RD_LATENCY];

   assign pat_cur    = pattern_word(pat_q, addr);
   assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign addr_last  = (addr == {ADDR_WIDTH{1'b1}});
   assign drain_last = (drain_cnt == 2'(RD_LATENCY - 1));
   assign mismatch   = vld_pipe[RD_LATENCY-1] && (ram_rdata != exp_pipe[RD_LATENCY-1]);
   assign err_next   = (mismatch && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;

   assign busy      = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
   assign ram_we    = (state == ST_WRITE);
   assign ram_addr  = addr;
   assign ram_wdata = ram_we ? pat_cur : '0;
   assign done      = done_q;
   assign pass      = pass_q;

   // Sequencer: the address is held at the top during DRAIN so the only wrap is WRITE -> READ.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         addr      <= '0;
         drain_cnt <= '0;
         pat_q     <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
`ifdef RAM_BIST_CONTINUOUS_EN
         done_q <= 1'b0;
`endif
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state  <= ST_WRITE;
                  addr   <= '0;
                  pat_q  <= pattern_sel;
                  done_q <= 1'b0;
                  pass_q <= 1'b0;
               end
            end
            ST_WRITE: begin
               if (addr_last) begin
                  state <= ST_READ;
                  addr  <= '0;
               end else begin
                  addr <= addr + ADDR_WIDTH'(1);
               end
            end
            ST_READ: begin
               if (addr_last) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= '0;
               end else begin
                  addr <= addr + ADDR_WIDTH'(1);
               end
            end
            ST_DRAIN: begin
               if (drain_last) begin
`ifdef RAM_BIST_CONTINUOUS_EN
                  state <= ST_WRITE;
                  addr  <= '0;
                  pat_q <= pat_q + 2'd1;
`else
                  state <= ST_DONE;
`endif
                  done_q <= 1'b1;
                  pass_q <= (err_next == 16'd0);
               end else begin
                  drain_cnt <= drain_cnt + 2'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Expected word and address travel alongside the RAM read latency so they meet ram_rdata.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            vld_pipe[i] <= 1'b0;
            exp_pipe[i] <= '0;
            adr_pipe[i] <= '0;
         end
      end else begin
         vld_pipe[0] <= (state == ST_READ);
         exp_pipe[0] <= pat_cur;
         adr_pipe[0] <= addr;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            exp_pipe[i] <= exp_pipe[i-1];
            adr_pipe[i] <= adr_pipe[i-1];
         end
      end
   end

   // A zero count means no mismatch yet this run, so it doubles as the first-error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
         err_addr  <= '0;
      end else if (start_ok) begin
         err_count <= '0;
         err_addr  <= '0;
      end else if (mismatch) begin
         err_count <= err_next;
         if (err_count == 16'd0) begin
            err_addr <= adr_pipe[RD_LATENCY-1];
         end
      end
   end

endmodule

// File: tb/tb_ram_72bit_bist_ctrl.sv
// tb_ram_72bit_bist_ctrl: drives BIST runs against a behavioural RAM with injectable read faults.
// Define RAM_BIST_CONTINUOUS_EN to exercise the looping build instead of the single-run build.
module tb_ram_72bit_bist_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 72;
   localparam int RL    = 1;
   localparam int DEPTH = 16;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      logic [15:0]   cnt;
      logic [AW-1:0] eaddr;
      logic          pass;
   } res_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    pattern_sel = 2'd0;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          busy;
   logic          done;
   logic          pass;
   logic [15:0]   err_count;
   logic [AW-1:0] err_addr;

   wr_t  wr_q[$];
   res_t res_q[$];
   int   total = 0;
   int   bad = 0;
   int   fault_mode = 0;
   logic [DW-1:0] mem [DEPTH];

   always #5 clk = ~clk;

   ram_72bit_bist_ctrl #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .RD_LATENCY(RL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .pattern_sel(pattern_sel),
      .ram_we(ram_we),
      .ram_addr(ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .busy(busy),
      .done(done),
      .pass(pass),
      .err_count(err_count),
      .err_addr(err_addr)
   );

   task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference patterns built bit by bit from the pattern definitions.
   function automatic logic [DW-1:0] modelPattern(input logic [1:0] sel, input logic [AW-1:0] a);
      logic [DW-1:0] w;
      for (int i = 0; i < DW; i++) begin
         case (sel)
            2'd0, 2'd3: w[i] = a[i[1:0]];
            2'd1:       w[i] = i[0] ^ a[0];
            default:    w[i] = (i == int'(a) % DW);
         endcase
      end
      if (sel == 2'd3) w = ~w;
      return w;
   endfunction

   function automatic logic [DW-1:0] faultFn(input int mode, input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = d;
      if (mode == 1 && a == 4'd5) r[0] = ~r[0];
      if (mode == 2) r[71] = 1'b0;
      return r;
   endfunction

   // Behavioural single-port RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= faultFn(fault_mode, ram_addr, mem[ram_addr]);
   end

   // Every write the DUT issues is matched against the scoreboard in order.
   always @(negedge clk) begin
      wr_t e;
      if (!rst && ram_we) begin
         if (wr_q.size() == 0) begin
            checkOutput("wr_extra", 1, 0);
         end else begin
            e = wr_q.pop_front();
            checkOutput("wr_addr", ram_addr, e.addr);
            checkOutput("wr_data", ram_wdata, e.data);
         end
      end
   end

   task automatic pushWrites(input logic [1:0] pat);
      wr_t w;
      for (int a = 0; a < DEPTH; a++) begin
         w.addr = AW'(a);
         w.data = modelPattern(pat, AW'(a));
         wr_q.push_back(w);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] pat, input int fault, input bit glitch, input bit abort);
      res_t r;
      int   cnt;
      bit   seen;
      bit   aborted;
      logic [DW-1:0] e;
      fault_mode = fault;
      pushWrites(pat);
      r.cnt = 0;
      r.eaddr = 0;
      for (int a = 0; a < DEPTH; a++) begin
         e = modelPattern(pat, AW'(a));
         if (faultFn(fault, AW'(a), e) !== e) begin
            if (r.cnt == 0) r.eaddr = AW'(a);
            r.cnt++;
         end
      end
      r.pass = (r.cnt == 0);
      res_q.push_back(r);

      @(negedge clk);
      start = 1'b1;
      pattern_sel = pat;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_on", busy, 1);
      checkOutput("done_clr", done, 0);
      cnt = 0;
      seen = 0;
      aborted = 0;
      for (int c = 0; c < 200; c++) begin
         start = 1'b0;
         if (busy) cnt++;
         if (done) begin
            seen = 1;
            break;
         end
         if (glitch && ram_we && ram_addr == 4'd7) begin
            start = 1'b1;
            pattern_sel = 2'd2;
         end
         if (abort && busy && !ram_we && ram_addr == 4'd9) begin
            rst = 1'b1;
            #1;
            checkOutput("abort_we", ram_we, 0);
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_done", done, 0);
            checkOutput("abort_errcnt", err_count, 0);
            void'(res_q.pop_front());
            @(negedge clk);
            rst = 1'b0;
            aborted = 1;
            break;
         end
         @(negedge clk);
      end
      if (aborted) return;
      r = res_q.pop_front();
      if (!seen) begin
         checkOutput("timeout", 0, 1);
         wr_q.delete();
         return;
      end
      checkOutput("busy_cycles", cnt, 2 * DEPTH + RL);
      checkOutput("err_count", err_count, r.cnt);
      checkOutput("err_addr", err_addr, r.eaddr);
      checkOutput("pass", pass, r.pass);
      checkOutput("wr_left", wr_q.size(), 0);
      repeat (3) @(negedge clk);
      checkOutput("done_hold", done, 1);
      checkOutput("busy_off", busy, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_pass", pass, 0);
      checkOutput("rst_errcnt", err_count, 0);
      checkOutput("rst_erraddr", err_addr, 0);
      checkOutput("rst_we", ram_we, 0);
      checkOutput("rst_addr", ram_addr, 0);
      checkOutput("rst_wdata", ram_wdata, 0);
      rst = 1'b0;
      @(negedge clk);

`ifdef RAM_BIST_CONTINUOUS_EN
      begin
         logic [1:0] ps;
         int pulses;
         int first;
         int lowbusy;
         bit prev_done;
         ps = 2'd3;
         repeat (3) begin
            pushWrites(ps);
            ps = ps + 2'd1;
         end
         fault_mode = 0;
         start = 1'b1;
         pattern_sel = 2'd3;
         @(negedge clk);
         start = 1'b0;
         pulses = 0;
         first = 0;
         lowbusy = 0;
         prev_done = 0;
         for (int c = 0; c < 90; c++) begin
            if (!busy) lowbusy++;
            if (prev_done) checkOutput("pulse_width", done, 0);
            if (done) begin
               pulses++;
               if (pulses == 1) begin
                  first = c;
                  checkOutput("pulse1_at", c, 2 * DEPTH + RL);
               end else begin
                  checkOutput("pulse_gap", c - first, 2 * DEPTH + RL);
               end
               checkOutput("pass_pulse", pass, 1);
               checkOutput("err_pulse", err_count, 0);
            end
            prev_done = done;
            @(negedge clk);
         end
         checkOutput("pulse_count", pulses, 2);
         checkOutput("busy_low", lowbusy, 0);
         checkOutput("wr_left", wr_q.size(), 0);
         rst = 1'b1;
         #1;
         checkOutput("stop_busy", busy, 0);
         @(negedge clk);
         rst = 1'b0;
      end
`else
      applyStimulus(2'd0, 0, 0, 0);
      applyStimulus(2'd1, 1, 0, 0);
      applyStimulus(2'd3, 2, 0, 0);
      applyStimulus(2'd0, 0, 1, 0);
      applyStimulus(2'd1, 0, 0, 1);
      applyStimulus(2'd2, 0, 0, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
